debug_snapshot: RTL and testbench

- Frame-synchronous capture stage directly upstream of the VGA text renderer.
- At each vertical-sync assertion, freezes the processor debug values (pc, instruction, immediate, rd_out, rs1_out, rs2_out, ruwr).
- Then sequentially scans the 32-entry register file into a shadow buffer.
- The renderer reads only stable, per-frame-coherent data, so digits do not tear mid-frame, and the renderer no longer drives the register-file read address.

---
 rtl/snap_pkg.sv | 18 +
 rtl/debug_snapshot_if.sv | 50 +++++
 rtl/sync_edge_detect.sv | 20 ++
 rtl/debug_snapshot.sv | 113 +++++++++++
 tb/tb_debug_snapshot.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/snap_pkg.sv
// Shared types and constants for the frame-synchronous debug snapshot stage.
package snap_pkg;

  localparam int unsigned REG_IDX_W   = 5;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned FRAME_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } snap_state_e;

  typedef logic [DATA_W-1:0]      word_t;
  typedef logic [REG_IDX_W-1:0]   reg_idx_t;
  typedef logic [FRAME_CNT_W-1:0] frame_cnt_t;

endpackage

// File: rtl/debug_snapshot_if.sv
// Processor-side, register-file and renderer-side signals of debug_snapshot.
// Carries disp_changed only when SNAP_CHANGE_FLAG_EN is defined.
interface debug_snapshot_if;
  import snap_pkg::*;

  word_t      pc_in, instruction_in, immediate_in;
  word_t      rd_out_in, rs1_out_in, rs2_out_in;
  logic       ruwr_in;

  reg_idx_t   rf_sel;
  word_t      rf_data;

  reg_idx_t   disp_sel;
  word_t      disp_reg;
`ifdef SNAP_CHANGE_FLAG_EN
  logic       disp_changed;
`endif

  word_t      pc_q, instruction_q, immediate_q;
  word_t      rd_out_q, rs1_out_q, rs2_out_q;
  logic       ruwr_q;
  logic       busy;
  logic       snap_valid;
  frame_cnt_t frame_count;

  // master: processor/register file/renderer side
  modport master (
`ifdef SNAP_CHANGE_FLAG_EN
    input  disp_changed,
`endif
    output pc_in, instruction_in, immediate_in, rd_out_in, rs1_out_in, rs2_out_in,
    output ruwr_in, rf_data, disp_sel,
    input  rf_sel, disp_reg,
    input  pc_q, instruction_q, immediate_q, rd_out_q, rs1_out_q, rs2_out_q,
    input  ruwr_q, busy, snap_valid, frame_count
  );

  // slave: the snapshot stage itself
  modport slave (
`ifdef SNAP_CHANGE_FLAG_EN
    output disp_changed,
`endif
    input  pc_in, instruction_in, immediate_in, rd_out_in, rs1_out_in, rs2_out_in,
    input  ruwr_in, rf_data, disp_sel,
    output rf_sel, disp_reg,
    output pc_q, instruction_q, immediate_q, rd_out_q, rs1_out_q, rs2_out_q,
    output ruwr_q, busy, snap_valid, frame_count
  );

endinterface

// File: rtl/sync_edge_detect.sv
// Registers vsync and produces a one-cycle pulse on the asserting edge of sync.
module sync_edge_detect #(
  parameter bit VSYNC_ACTIVE_LOW = 1'b1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic vsync,
  output logic sync_edge
);

  logic vsync_prev;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) vsync_prev <= 1'b0;
    else          vsync_prev <= vsync;
  end

  assign sync_edge = VSYNC_ACTIVE_LOW ? (vsync_prev & ~vsync) : (~vsync_prev & vsync);

endmodule

// File: rtl/debug_snapshot.sv
// Freezes processor debug values on vsync and scans the register file into a
// shadow buffer for the text renderer. Optional: SNAP_CHANGE_FLAG_EN adds per-entry change flags.
module debug_snapshot
  import snap_pkg::*;
#(
  parameter int unsigned NUM_REGS         = 32,
  parameter bit          VSYNC_ACTIVE_LOW = 1'b1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             vsync,
  input  logic             freeze,
  debug_snapshot_if.slave  dbg
);

  localparam reg_idx_t               LAST_IDX   = REG_IDX_W'(NUM_REGS - 1);
  localparam logic [REG_IDX_W:0]     NUM_REGS_X = (REG_IDX_W + 1)'(NUM_REGS);

  snap_state_e state, state_nxt;
  reg_idx_t    cnt;
  logic        sync_edge;
  logic        start;
  logic        sel_in_range;
  word_t       shadow [NUM_REGS];

  sync_edge_detect #(
    .VSYNC_ACTIVE_LOW (VSYNC_ACTIVE_LOW)
  ) u_sync_edge_detect (
    .clock     (clock),
    .reset_n   (reset_n),
    .vsync     (vsync),
    .sync_edge (sync_edge)
  );

  assign start        = (state == IDLE) && sync_edge && !freeze;
  assign sel_in_range = {1'b0, dbg.disp_sel} < NUM_REGS_X;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    dbg.rf_sel = '0;
    dbg.busy   = (state != IDLE);
    case (state)
      IDLE: if (start) state_nxt = SCAN;
      SCAN: begin
        dbg.rf_sel = cnt;
        if (cnt == LAST_IDX) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt               <= '0;
      dbg.pc_q          <= '0;
      dbg.instruction_q <= '0;
      dbg.immediate_q   <= '0;
      dbg.rd_out_q      <= '0;
      dbg.rs1_out_q     <= '0;
      dbg.rs2_out_q     <= '0;
      dbg.ruwr_q        <= 1'b0;
      dbg.snap_valid    <= 1'b0;
      dbg.frame_count   <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) shadow[i] <= '0;
    end else begin
      if (start) begin
        dbg.pc_q          <= dbg.pc_in;
        dbg.instruction_q <= dbg.instruction_in;
        dbg.immediate_q   <= dbg.immediate_in;
        dbg.rd_out_q      <= dbg.rd_out_in;
        dbg.rs1_out_q     <= dbg.rs1_out_in;
        dbg.rs2_out_q     <= dbg.rs2_out_in;
        dbg.ruwr_q        <= dbg.ruwr_in;
        cnt               <= '0;
      end
      if (state == SCAN) begin
        shadow[cnt] <= dbg.rf_data;
        cnt         <= cnt + 1'b1;
      end
      if (state == DONE) begin
        dbg.frame_count <= dbg.frame_count + 1'b1;
        dbg.snap_valid  <= 1'b1;
      end
    end
  end

  always_comb begin
    dbg.disp_reg = '0;
    if (sel_in_range) dbg.disp_reg = shadow[dbg.disp_sel];
  end

`ifdef SNAP_CHANGE_FLAG_EN
  logic [NUM_REGS-1:0] change_flag;

  // shadow[cnt] still holds the previous frame's value when compared here
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)            change_flag      <= '0;
    else if (state == SCAN)  change_flag[cnt] <= (dbg.rf_data != shadow[cnt]);
  end

  always_comb begin
    dbg.disp_changed = 1'b0;
    if (sel_in_range) dbg.disp_changed = change_flag[dbg.disp_sel];
  end
`endif

endmodule

// File: tb/tb_debug_snapshot.sv
// Directed self-checking bench for debug_snapshot with a behavioural register file.
module tb_debug_snapshot;

  logic clock = 1'b0;
  logic reset_n;
  logic vsync;
  logic freeze;

  int total = 0;
  int bad   = 0;

  logic [31:0] rf [32];
  logic [31:0] v;
  int          n;
  logic [4:0]  sel10;

  always #10 clock = ~clock;

  debug_snapshot_if dbg_if ();

  assign dbg_if.rf_data = rf[dbg_if.rf_sel];

  debug_snapshot #(
    .NUM_REGS         (32),
    .VSYNC_ACTIVE_LOW (1'b1)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .vsync   (vsync),
    .freeze  (freeze),
    .dbg     (dbg_if.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int k);
    repeat (k) @(posedge clock);
    #1;
  endtask

  task automatic vsync_fall;
    @(negedge clock) vsync = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic vsync_rise;
    @(negedge clock) vsync = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic peek(input logic [4:0] sel, output logic [31:0] val);
    dbg_if.disp_sel = sel;
    #1;
    val = dbg_if.disp_reg;
  endtask

  // Counts post-edge samples with busy high, starting at the current sample.
  task automatic wait_idle(output int cnt, output logic [4:0] sel_at10);
    cnt      = 0;
    sel_at10 = 5'h1f;
    while (dbg_if.busy && cnt < 100) begin
      if (cnt == 10) sel_at10 = dbg_if.rf_sel;
      cnt++;
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    reset_n = 1'b0;
    vsync   = 1'b1;
    freeze  = 1'b0;
    dbg_if.pc_in          = '0;
    dbg_if.instruction_in = '0;
    dbg_if.immediate_in   = '0;
    dbg_if.rd_out_in      = '0;
    dbg_if.rs1_out_in     = '0;
    dbg_if.rs2_out_in     = '0;
    dbg_if.ruwr_in        = 1'b0;
    dbg_if.disp_sel       = '0;
    for (int i = 0; i < 32; i++) rf[i] = 32'h1000_0000 + i;

    cycles(3);
    @(negedge clock) reset_n = 1'b1;
    cycles(4);

    check("rst_snap_valid", 32'(dbg_if.snap_valid), 32'd0);
    check("rst_frame_count", 32'(dbg_if.frame_count), 32'd0);
    check("rst_busy", 32'(dbg_if.busy), 32'd0);
    check("rst_pc_q", dbg_if.pc_q, 32'd0);
    check("rst_rf_sel", 32'(dbg_if.rf_sel), 32'd0);
    for (int i = 0; i < 32; i++) begin
      peek(5'(i), v);
      check("rst_disp_reg", v, 32'd0);
    end

    // Frame 1
    dbg_if.pc_in          = 32'h0000_0040;
    dbg_if.instruction_in = 32'h00A0_0093;
    dbg_if.rs2_out_in     = 32'h0000_1234;
    dbg_if.ruwr_in        = 1'b1;
    vsync_fall;
    check("f1_pc_q_at_E", dbg_if.pc_q, 32'h0000_0040);
    check("f1_instr_q", dbg_if.instruction_q, 32'h00A0_0093);
    check("f1_rs2_q", dbg_if.rs2_out_q, 32'h0000_1234);
    check("f1_ruwr_q", 32'(dbg_if.ruwr_q), 32'd1);
    check("f1_busy_at_E", 32'(dbg_if.busy), 32'd1);
    check("f1_snap_valid_mid", 32'(dbg_if.snap_valid), 32'd0);
    wait_idle(n, sel10);
    check("f1_busy_cycles", 32'(n), 32'd33);
    check("f1_rf_sel_scan10", 32'(sel10), 32'd10);
    check("f1_frame_count", 32'(dbg_if.frame_count), 32'd1);
    check("f1_snap_valid", 32'(dbg_if.snap_valid), 32'd1);
    check("f1_rf_sel_idle", 32'(dbg_if.rf_sel), 32'd0);
    peek(5'd7, v);  check("f1_disp7", v, 32'h1000_0007);
    peek(5'd0, v);  check("f1_disp0", v, 32'h1000_0000);
    peek(5'd31, v); check("f1_disp31", v, 32'h1000_001F);
    vsync_rise;
    cycles(5);

    // Live changes must not leak before the next edge
    dbg_if.pc_in = 32'h0000_0044;
    rf[5]        = 32'hDEAD_BEEF;
    cycles(3);
    check("f2_pc_q_hold", dbg_if.pc_q, 32'h0000_0040);
    peek(5'd5, v); check("f2_disp5_hold", v, 32'h1000_0005);
    vsync_fall;
    check("f2_pc_q_at_E", dbg_if.pc_q, 32'h0000_0044);
    wait_idle(n, sel10);
    check("f2_busy_cycles", 32'(n), 32'd33);
    peek(5'd5, v); check("f2_disp5_new", v, 32'hDEAD_BEEF);
    check("f2_frame_count", 32'(dbg_if.frame_count), 32'd2);
    vsync_rise;

    // Freeze across three edges
    @(negedge clock) freeze = 1'b1;
    dbg_if.pc_in = 32'h0000_0048;
    for (int e = 0; e < 3; e++) begin
      vsync_fall;
      check("frz_busy_at_E", 32'(dbg_if.busy), 32'd0);
      cycles(2);
      check("frz_busy_after", 32'(dbg_if.busy), 32'd0);
      vsync_rise;
    end
    check("frz_pc_q", dbg_if.pc_q, 32'h0000_0044);
    check("frz_frame_count", 32'(dbg_if.frame_count), 32'd2);
    @(negedge clock) freeze = 1'b0;
    cycles(2);
    check("unfrz_busy", 32'(dbg_if.busy), 32'd0);

    // Second edge during scan is ignored
    dbg_if.pc_in = 32'h0000_0050;
    vsync_fall;
    check("f3_pc_q_at_E", dbg_if.pc_q, 32'h0000_0050);
    dbg_if.pc_in = 32'h0000_0054;
    vsync_rise;
    cycles(7);
    vsync_fall;
    check("f3_busy_mid", 32'(dbg_if.busy), 32'd1);
    check("f3_pc_q_mid", dbg_if.pc_q, 32'h0000_0050);
    wait_idle(n, sel10);
    check("f3_busy_rest", 32'(n), 32'd24);
    check("f3_frame_count", 32'(dbg_if.frame_count), 32'd3);
    cycles(3);
    check("f3_no_rescan", 32'(dbg_if.busy), 32'd0);
    check("f3_pc_q_final", dbg_if.pc_q, 32'h0000_0050);

    // Reset in the middle of a scan
    vsync_rise;
    cycles(2);
    dbg_if.pc_in = 32'h0000_0060;
    vsync_fall;
    cycles(20);
    check("f4_busy_mid", 32'(dbg_if.busy), 32'd1);
    @(negedge clock) reset_n = 1'b0;
    #1;
    check("rst2_busy", 32'(dbg_if.busy), 32'd0);
    check("rst2_frame_count", 32'(dbg_if.frame_count), 32'd0);
    check("rst2_snap_valid", 32'(dbg_if.snap_valid), 32'd0);
    check("rst2_pc_q", dbg_if.pc_q, 32'd0);
    check("rst2_rf_sel", 32'(dbg_if.rf_sel), 32'd0);
    peek(5'd7, v); check("rst2_disp7", v, 32'd0);
    vsync = 1'b1;
    @(negedge clock) reset_n = 1'b1;
    cycles(3);
    check("rst2_idle", 32'(dbg_if.busy), 32'd0);
    check("rst2_frame_after", 32'(dbg_if.frame_count), 32'd0);
    check("rst2_valid_after", 32'(dbg_if.snap_valid), 32'd0);

`ifdef SNAP_CHANGE_FLAG_EN
    vsync_fall;
    wait_idle(n, sel10);
    vsync_rise;
    cycles(2);
    rf[3] = 32'h3333_3333;
    vsync_fall;
    wait_idle(n, sel10);
    check("cf_frame_count", 32'(dbg_if.frame_count), 32'd2);
    for (int i = 0; i < 32; i++) begin
      dbg_if.disp_sel = 5'(i);
      #1;
      check("cf_disp_changed", 32'(dbg_if.disp_changed), (i == 3) ? 32'd1 : 32'd0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
